// File: rtl/bsr_chain.sv
// Boundary-scan register chain: capture/shift/update stages on one clock with
// synchronous enables, a programmable safe update value and a saturating shift counter.
module bsr_chain #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] p_o,
  input  logic             tdi,
  output logic             tdo,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             mode,
  output logic [CNT_W-1:0] shift_count,
  output logic             scan_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] ur_q, ur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: capture wins over shift; update always samples the pre-edge shift stage.
  always_comb begin
    sr_d  = sr_q;
    ur_d  = ur_q;
    cnt_d = cnt_q;
    if (capture_dr) begin
      sr_d  = p_i;
      cnt_d = '0;
    end else if (shift_dr) begin
      sr_d = {tdi, sr_q[WIDTH-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (update_dr) begin
      ur_d = sr_q;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sr_q  <= '0;
      ur_q  <= SAFE_VAL;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ur_q  <= ur_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are combinational so mode/p_i changes reach the pins without a clock.
  assign tdo         = sr_q[0];
  assign p_o         = mode ? ur_q : p_i;
  assign shift_count = cnt_q;
  assign scan_full   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_bsr_chain.sv
// Scoreboard bench for bsr_chain: three widths (8, 2, 33) driven in lockstep and
// checked each cycle against a queue-of-bits reference model.
module tb_bsr_chain;

  localparam int unsigned W0 = 8;
  localparam int unsigned W1 = 2;
  localparam int unsigned W2 = 33;
  localparam int unsigned C0 = $clog2(W0 + 1);
  localparam int unsigned C1 = $clog2(W1 + 1);
  localparam int unsigned C2 = $clog2(W2 + 1);
  localparam logic [W0-1:0] S0 = 8'hA5;
  localparam logic [W1-1:0] S1 = 2'b10;
  localparam logic [W2-1:0] S2 = 33'h1_2345_6789;

  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic trst_n, tdi, capture_dr, shift_dr, update_dr, mode;
  logic [63:0] pi_v [3];

  logic [W0-1:0] p_i0, p_o0;
  logic [W1-1:0] p_i1, p_o1;
  logic [W2-1:0] p_i2, p_o2;
  logic tdo0, tdo1, tdo2, full0, full1, full2;
  logic [C0-1:0] sc0;
  logic [C1-1:0] sc1;
  logic [C2-1:0] sc2;

  assign p_i0 = pi_v[0][W0-1:0];
  assign p_i1 = pi_v[1][W1-1:0];
  assign p_i2 = pi_v[2][W2-1:0];

  bsr_chain #(.WIDTH(W0), .SAFE_VAL(S0)) u_dut0 (
    .tck(tck), .trst_n(trst_n), .p_i(p_i0), .p_o(p_o0), .tdi(tdi), .tdo(tdo0),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .mode(mode),
    .shift_count(sc0), .scan_full(full0));
  bsr_chain #(.WIDTH(W1), .SAFE_VAL(S1)) u_dut1 (
    .tck(tck), .trst_n(trst_n), .p_i(p_i1), .p_o(p_o1), .tdi(tdi), .tdo(tdo1),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .mode(mode),
    .shift_count(sc1), .scan_full(full1));
  bsr_chain #(.WIDTH(W2), .SAFE_VAL(S2)) u_dut2 (
    .tck(tck), .trst_n(trst_n), .p_i(p_i2), .p_o(p_o2), .tdi(tdi), .tdo(tdo2),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .mode(mode),
    .shift_count(sc2), .scan_full(full2));

  typedef struct packed {
    logic [2:0]       tdo;
    logic [2:0]       full;
    logic [2:0][63:0] po;
    logic [2:0][7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: chain[L][0] is the cell nearest tdo.
  int unsigned wid [3] = '{W0, W1, W2};
  logic [63:0] safe [3] = '{64'(S0), 64'(S1), 64'(S2)};
  bit chain [3][$];
  logic [63:0] ur_m [3];
  int cnt_m [3];

  function automatic logic [63:0] mask(int l);
    return (64'd1 << wid[l]) - 64'd1;
  endfunction

  function automatic logic [63:0] pack(int l);
    logic [63:0] v = '0;
    for (int i = 0; i < chain[l].size(); i++) v[i] = chain[l][i];
    return v;
  endfunction

  function automatic void model_reset(int l);
    chain[l].delete();
    for (int i = 0; i < int'(wid[l]); i++) chain[l].push_back(1'b0);
    ur_m[l] = safe[l];
    cnt_m[l] = 0;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    for (int l = 0; l < 3; l++) begin
      e.tdo[l]  = chain[l][0];
      e.po[l]   = mode ? ur_m[l] : (pi_v[l] & mask(l));
      e.cnt[l]  = 8'(cnt_m[l]);
      e.full[l] = (cnt_m[l] == int'(wid[l]));
    end
    return e;
  endfunction

  function automatic void model_step();
    logic [63:0] old;
    for (int l = 0; l < 3; l++) begin
      old = pack(l);
      if (!trst_n) begin
        model_reset(l);
      end else begin
        if (capture_dr) begin
          chain[l].delete();
          for (int i = 0; i < int'(wid[l]); i++) chain[l].push_back(pi_v[l][i]);
          cnt_m[l] = 0;
        end else if (shift_dr) begin
          void'(chain[l].pop_front());
          chain[l].push_back(tdi);
          if (cnt_m[l] < int'(wid[l])) cnt_m[l]++;
        end
        if (update_dr) ur_m[l] = old;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic get_act(input int l, output logic t, output logic [63:0] po,
                         output logic [63:0] c, output logic f);
    case (l)
      0: begin t = tdo0; po = 64'(p_o0); c = 64'(sc0); f = full0; end
      1: begin t = tdo1; po = 64'(p_o1); c = 64'(sc1); f = full1; end
      default: begin t = tdo2; po = 64'(p_o2); c = 64'(sc2); f = full2; end
    endcase
  endtask

  task automatic compare_all(input exp_t e, input string tag);
    logic t, f;
    logic [63:0] po, c;
    for (int l = 0; l < 3; l++) begin
      get_act(l, t, po, c, f);
      chk($sformatf("%s_tdo_w%0d", tag, wid[l]), 64'(t), 64'(e.tdo[l]));
      chk($sformatf("%s_po_w%0d", tag, wid[l]), po, e.po[l]);
      chk($sformatf("%s_cnt_w%0d", tag, wid[l]), c, 64'(e.cnt[l]));
      chk($sformatf("%s_full_w%0d", tag, wid[l]), 64'(f), 64'(e.full[l]));
    end
  endtask

  // Monitor: one expected response per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge tck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all(e, "edge");
      end
    end
  end

  // Driver: inputs change 2 units after an edge; the model response is queued for the next edge.
  task automatic cycle(input logic cap, input logic sh, input logic upd,
                       input logic td, input logic md, input logic rn);
    capture_dr = cap; shift_dr = sh; update_dr = upd; tdi = td; mode = md; trst_n = rn;
    model_step();
    exp_q.push_back(model_outputs());
    @(posedge tck);
    #2;
  endtask

  task automatic async_reset();
    trst_n = 1'b0;
    for (int l = 0; l < 3; l++) model_reset(l);
    #1;
    compare_all(model_outputs(), "async_rst");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, mode, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, mode, 1'b1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] pat;
    int r;
    trst_n = 1'b0; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0;
    update_dr = 1'b0; mode = 1'b1;
    for (int l = 0; l < 3; l++) begin
      pi_v[l] = '0;
      model_reset(l);
    end
    @(posedge tck);
    #2;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_po", 64'(p_o0), 64'h A5);
    chk("reset_cnt", 64'(sc0), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Capture 3C and shift it out LSB first.
    pi_v[0] = 64'h3C; pi_v[1] = 64'h1; pi_v[2] = 64'h1_8000_0001;
    seq = 8'h3C;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cap_tdo0", 64'(tdo0), 64'(seq[0]));
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      if (k < 8) chk($sformatf("shift_tdo%0d", k), 64'(tdo0), 64'(seq[k]));
      if (k == 7) chk("full_before_8", 64'(full0), 64'd0);
    end
    chk("full_at_8", 64'(full0), 64'd1);

    // Shift in C3, update, drive pins, then back to pass-through.
    pat = 8'hC3;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, pat[k], 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("extest_po", 64'(p_o0), 64'h C3);
    pi_v[0] = 64'h5A;
    mode = 1'b0;
    #1;
    chk("passthru_po", 64'(p_o0), 64'h5A);

    // Capture and shift together: capture wins. Then update alongside a shift.
    pi_v[0] = 64'hFF; pi_v[1] = 64'h3; pi_v[2] = 64'h0_FFFF_0000;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("capshift_tdo", 64'(tdo0), 64'd1);
    chk("capshift_cnt", 64'(sc0), 64'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("updshift_po", 64'(p_o0), 64'h FF);

    // Saturation: 12 shifts after capture.
    pi_v[0] = 64'h96;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 12; k++) cycle(1'b0, 1'b1, 1'b0, 1'(k & 1), 1'b1, 1'b1);
    chk("sat_cnt", 64'(sc0), 64'd8);

    // Round-trip latency: a single 1 on tdi through zeroed chains.
    pi_v[0] = '0; pi_v[1] = '0; pi_v[2] = '0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 40; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      if (k == int'(W2) - 1) chk("latency_w33", 64'(tdo2), 64'd1);
    end

    // Async reset mid-scan.
    pi_v[0] = 64'hE7;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    async_reset();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < 3; l++) pi_v[l] = {32'($urandom), 32'($urandom)} & mask(l);
      r = int'($urandom_range(0, 199));
      if (r == 199) begin
        async_reset();
      end else begin
        cycle(r < 12, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              1'($urandom), 1'($urandom), 1'b1);
      end
    end

    @(posedge tck);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsr_chain.md
# bsr_chain

Parametrised boundary-scan register for the JTAG block: a WIDTH-cell chain with capture, shift and update stages. It sits between core pins and the TAP controller, taking per-stage enables from the TAP. It replaces per-cell gated clocks with a single clock and synchronous enables. It adds a programmable safe reset value and a shift-length counter that flags a complete scan.

## Interface

Parameters:
- WIDTH, default 8: number of boundary cells (≥ 2).
- SAFE_VAL, default all-zeros, WIDTH bits: update-stage value after reset.

Ports:
- tck  in  1  scan clock; all state changes on its rising edge.
- trst_n  in  1  reset, asynchronous, active-low.
- p_i  in  WIDTH  system-side inputs, one bit per cell.
- p_o  out  WIDTH  pin-side outputs.
- tdi  in  1  serial scan in.
- tdo  out  1  serial scan out.
- capture_dr  in  1  load p_i into the shift stage.
- shift_dr  in  1  shift chain one position toward tdo.
- update_dr  in  1  copy shift stage into update stage.
- mode  in  1  0 = functional pass-through, 1 = drive p_o from update stage.
- shift_count  out  $clog2(WIDTH+1)  bits shifted since last capture, saturating.
- scan_full  out  1  high when shift_count == WIDTH.

## Operation

- State: shift stage sr[WIDTH-1:0], update stage ur[WIDTH-1:0], counter cnt.
- Asynchronous reset (trst_n low): sr = 0, ur = SAFE_VAL, cnt = 0. Reset takes effect immediately and holds while trst_n is low. It aborts any scan in progress; no partial shift survives.
- Capture (capture_dr = 1): sr <= p_i, cnt <= 0.
- Shift (shift_dr = 1, capture_dr = 0):
  - sr <= {tdi, sr[WIDTH-1:1]}: tdi enters cell WIDTH-1, cell 0 leaves via tdo.
  - cnt <= min(cnt+1, WIDTH).
- Enable priority: capture_dr overrides shift_dr. When both are high, capture happens and no shift occurs.
- Update (update_dr = 1): ur <= sr, using the pre-edge value of sr.
  - update_dr is independent of the other enables.
  - If update_dr coincides with capture or shift, ur takes the old sr while sr takes its new value.
  - cnt is unaffected by update.
- No enable asserted: sr, ur and cnt hold.
- tdo = sr[0], combinational from the register with no extra stage.
- p_o = mode ? ur : p_i, combinational, so mode and p_i changes propagate with no clock.
- scan_full = (cnt == WIDTH), combinational from cnt.
- cnt saturates at WIDTH and never wraps. Further shifts keep moving data while scan_full stays high.

## Timing

- Reset values:
  - tdo = 0, shift_count = 0, scan_full = 0.
  - p_o = SAFE_VAL when mode = 1, p_i when mode = 0.
- Capture latency: 1 tck. tdo shows p_i[0] right after the capture edge.
- Shift latency:
  - A bit on tdi at edge k appears on tdo after edge k+WIDTH-1.
  - The original sr[i] appears on tdo after i shift edges.
- Update latency: 1 tck from update_dr edge to ur. p_o follows combinationally if mode = 1.
- scan_full rises on the WIDTH-th shift edge after a capture. It falls on the next capture or reset.
- trst_n deassertion is synchronous to tck from the integrator's side. The first edge with trst_n high acts on enables normally.

## Test plan

- Reset, WIDTH=8, SAFE_VAL=8'hA5, mode=1:
  - Pulse trst_n low mid-scan -> p_o=8'hA5, tdo=0, shift_count=0, scan_full=0 immediately, without waiting for a tck edge.
- Capture/shift-out:
  - p_i=8'h3C, one capture_dr cycle, then 8 shift_dr cycles with tdi=0 -> tdo sequence 0,0,1,1,1,1,0,0 (LSB first).
  - scan_full rises on the 8th shift edge.
- Shift-in/update/extest:
  - Shift 8'hC3 LSB first, then update_dr with mode=1 -> p_o=8'hC3 on the following cycle.
  - Set mode=0 -> p_o=p_i.
- Simultaneous enables:
  - capture_dr and shift_dr both high with p_i=8'hFF -> sr=8'hFF, no shift, cnt=0.
  - update_dr with shift_dr -> ur gets the pre-shift sr.
- Saturation: capture then 12 shifts -> shift_count stays 8 from shift 8 on, scan_full stays 1, data keeps moving to tdo.
- Parameter sweep: WIDTH=2 and WIDTH=33 -> shift_count width is 2 and 6 bits, and the round-trip latency tdi->tdo is WIDTH-1 edges.
